// File: rtl/p5_mul_seq.sv
// Sequential unsigned 16x16->16 shift-and-add multiplier that borrows the shared
// ALU for its additions; start/busy/done handshake toward the controller.
module p5_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [4:0]       cnt_q;
  logic             ovf_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             carry_s;
  logic             ovf_d;
  logic             last_s;
  logic             unused_flags_s;

  // Signed ALU flags carry no meaning for unsigned products.
  assign unused_flags_s = alu_n ^ alu_v ^ alu_z;

  // Carry out of acc+mcand recovered from the sum MSB, plus bits lost off the top of mcand.
  always_comb begin
    carry_s = (acc_q[WIDTH-1] & mcand_q[WIDTH-1])
            | ((acc_q[WIDTH-1] | mcand_q[WIDTH-1]) & ~alu_out[WIDTH-1]);
    ovf_d   = ovf_q
            | (mplier_q[0] & carry_s)
            | (mcand_q[WIDTH-1] & (mplier_q[WIDTH-1:1] != {(WIDTH-1){1'b0}}));
    last_s  = (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (cnt_q == 5'd15);
  end

  // Control FSM and datapath registers, one multiplier bit per STEP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= 5'd0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a_in;
            mplier_q <= b_in;
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= 5'd0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_STEP;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        S_STEP: begin
          if (mplier_q[0]) begin
            acc_q <= alu_out;
          end
          ovf_q    <= ovf_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (last_s) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          zero_q  <= (acc_q == {WIDTH{1'b0}});
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;
  assign ovf     = ovf_q;
  assign zero    = zero_q;
  assign alu_ain = acc_q;
  assign alu_bin = mcand_q;
  assign alu_op  = 2'b00;

endmodule

// File: tb/tb_p5_mul_seq.sv
// Directed self-checking bench for p5_mul_seq; a behavioural adder stands in for the shared ALU.
module tb_p5_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic        zero;
  logic [15:0] alu_ain;
  logic [15:0] alu_bin;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_n;
  logic        alu_v;
  logic        alu_z;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign alu_out = alu_ain + alu_bin;
  assign alu_n   = alu_out[15];
  assign alu_z   = (alu_out == 16'h0000);
  assign alu_v   = (alu_ain[15] == alu_bin[15]) && (alu_out[15] != alu_ain[15]);

  p5_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .ovf(ovf), .zero(zero),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op), .alu_out(alu_out),
    .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z)
  );

  // Issues one start and returns the number of edges after the accepting edge until done is seen (-1 on timeout).
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, output int n);
    @(posedge clk); #1;
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) n = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a_in = 16'h0000; b_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({busy, done, ovf, zero} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got busy/done/ovf/zero=%b exp 0000", {busy, done, ovf, zero});
    end
    tests++; if (product !== 16'h0000) begin
      fails++; $display("FAIL reset_product: got %h exp 0000", product);
    end
    tests++; if (alu_op !== 2'b00) begin
      fails++; $display("FAIL reset_aluop: got %b exp 00", alu_op);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    do_mul(16'd3, 16'd5, n);
    tests++; if (n !== 3) begin
      fails++; $display("FAIL basic_latency: got %0d exp 3", n);
    end
    tests++; if ({product, ovf, zero} !== {16'd15, 1'b0, 1'b0}) begin
      fails++; $display("FAIL basic_result: got prod=%h ovf=%b zero=%b exp 000f 0 0", product, ovf, zero);
    end
    tests++; if (alu_op !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_op_busy: got op=%b busy=%b exp 00 0", alu_op, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (product !== 16'd15 || done !== 1'b0) begin
      fails++; $display("FAIL basic_hold: got prod=%h done=%b exp 000f 0", product, done);
    end
  endtask

  task automatic test_zero_mplier;
    int n;
    do_mul(16'h1234, 16'h0000, n);
    tests++; if (n !== 1) begin
      fails++; $display("FAIL zero_b_latency: got %0d exp 1", n);
    end
    @(posedge clk); #1;
    tests++; if ({product, ovf, zero} !== {16'h0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL zero_b_result: got prod=%h ovf=%b zero=%b exp 0000 0 1", product, ovf, zero);
    end
  endtask

  task automatic test_overflow;
    int n;
    do_mul(16'h0100, 16'h0100, n);
    @(posedge clk); #1;
    tests++; if ({product, ovf, zero} !== {16'h0000, 1'b1, 1'b1}) begin
      fails++; $display("FAIL ovf_shift: got prod=%h ovf=%b zero=%b exp 0000 1 1", product, ovf, zero);
    end
    do_mul(16'hFFFF, 16'h0002, n);
    @(posedge clk); #1;
    tests++; if ({product, ovf, zero} !== {16'hFFFE, 1'b1, 1'b0}) begin
      fails++; $display("FAIL ovf_ffff_x2: got prod=%h ovf=%b zero=%b exp fffe 1 0", product, ovf, zero);
    end
    do_mul(16'hF000, 16'h0003, n);
    tests++; if (product !== 16'hD000 || ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_carry: got prod=%h ovf=%b exp d000 1", product, ovf);
    end
  endtask

  task automatic test_boundary;
    int n;
    do_mul(16'h0001, 16'h8000, n);
    tests++; if (n !== 16) begin
      fails++; $display("FAIL worst_latency: got %0d exp 16", n);
    end
    tests++; if (product !== 16'h8000 || ovf !== 1'b0) begin
      fails++; $display("FAIL worst_result: got prod=%h ovf=%b exp 8000 0", product, ovf);
    end
    do_mul(16'hFFFF, 16'h0001, n);
    tests++; if (n !== 1 || product !== 16'hFFFF || ovf !== 1'b0) begin
      fails++; $display("FAIL ffff_x1: got n=%0d prod=%h ovf=%b exp 1 ffff 0", n, product, ovf);
    end
    do_mul(16'h0000, 16'hABCD, n);
    @(posedge clk); #1;
    tests++; if ({product, ovf, zero} !== {16'h0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL zero_a: got prod=%h ovf=%b zero=%b exp 0000 0 1", product, ovf, zero);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int extra;
    @(posedge clk); #1;
    a_in = 16'd7; b_in = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a_in = 16'd100; b_in = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(posedge clk); #1;
      n++;
    end
    tests++; if (n !== 4) begin
      fails++; $display("FAIL repulse_latency: got %0d exp 4", n);
    end
    tests++; if (product !== 16'd63 || ovf !== 1'b0) begin
      fails++; $display("FAIL repulse_result: got prod=%0d ovf=%b exp 63 0", product, ovf);
    end
    a_in = 16'd2; b_in = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) extra++;
      @(posedge clk); #1;
    end
    tests++; if (extra !== 0 || product !== 16'd63) begin
      fails++; $display("FAIL start_in_done: got activity=%0d prod=%0d exp 0 63", extra, product);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(posedge clk); #1;
    a_in = 16'd7; b_in = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if ({busy, done, ovf, zero, product} !== {4'b0000, 16'h0000}) begin
      fails++; $display("FAIL reset_mid: got busy=%b done=%b ovf=%b zero=%b prod=%h exp 0 0 0 0 0000",
                        busy, done, ovf, zero, product);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    tests++; if (pulses !== 0 || product !== 16'h0000) begin
      fails++; $display("FAIL reset_mid_quiet: got activity=%0d prod=%h exp 0 0000", pulses, product);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mplier();
    test_overflow();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
